// File: rtl/speed_tick_pkg.sv
// Shared helpers for the speed tick selector: rate divisors, select clamping,
// parameter sanity check and the run/pause mode encoding.
package speed_tick_pkg;

  // Run/pause mode, decoded straight from the synchronised run switch.
  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } mode_e;

  // Divisor of speed k: each step halves the tick period.
  function automatic int unsigned div_of(input int unsigned base, input int unsigned k);
    return base >> k;
  endfunction

  // Out-of-range selects fall back to the fastest rate.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n);
    return (sel >= n) ? (n - 1) : sel;
  endfunction

  // The fastest rate must still divide by at least 2 so tick cannot stick high.
  function automatic bit range_ok(input int unsigned base, input int unsigned n);
    return (n >= 2) && ((base >> (n - 1)) >= 2);
  endfunction

endpackage

// File: rtl/speed_tick_sel_sync2.sv
// Two-flop synchroniser for asynchronous switch inputs, cleared by reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/speed_tick_sel.sv
// Single-clock rate selector: divides clk by one of N_SPEEDS rates and emits a
// one-cycle tick plus a 50% square wave. Rate changes land only on a period
// boundary while running; a paused re-select restarts a full period.
module speed_tick_sel #(
  parameter int N_SPEEDS = 4,
  parameter int BASE_DIV = 50_000_000,
  parameter int SEL_W    = $clog2(N_SPEEDS),
  parameter int CNT_W    = $clog2(BASE_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sw,
  input  logic             en,
  output logic             tick,
  output logic             wave,
  output logic [SEL_W-1:0] active_sel,
  output logic             running
);

  import speed_tick_pkg::*;

  if (!range_ok(BASE_DIV, N_SPEEDS)) begin : g_bad_params
    $error("speed_tick_sel: N_SPEEDS must be >= 2 and BASE_DIV >> (N_SPEEDS-1) >= 2");
  end

  logic [SEL_W-1:0] w_sw_s;
  logic [SEL_W-1:0] w_sel_c;
  logic             w_run;
  mode_e            w_mode;
  logic [CNT_W-1:0] w_reload;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_wave;
  logic [SEL_W-1:0] r_active;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tick_nxt;
  logic             w_wave_nxt;
  logic [SEL_W-1:0] w_active_nxt;

  sync2 #(.WIDTH(SEL_W)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (w_sw_s)
  );

  sync2 #(.WIDTH(1)) u_sync_en (
    .clk (clk),
    .rst (rst),
    .d   (en),
    .q   (w_run)
  );

  assign w_mode   = w_run ? RUN : PAUSE;
  assign w_sel_c  = SEL_W'(clamp_sel(32'(w_sw_s), N_SPEEDS));
  assign w_reload = CNT_W'(div_of(BASE_DIV, 32'(w_sel_c)) - 1);

  // Next counter/output values: reload at terminal count, otherwise count down
  // while running; while paused only a changed select reloads.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_tick_nxt   = 1'b0;
    w_wave_nxt   = r_wave;
    w_active_nxt = r_active;
    case (w_mode)
      RUN: begin
        if (r_cnt == '0) begin
          w_tick_nxt   = 1'b1;
          w_wave_nxt   = ~r_wave;
          w_active_nxt = w_sel_c;
          w_cnt_nxt    = w_reload;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      PAUSE: begin
        if (w_sel_c != r_active) begin
          w_active_nxt = w_sel_c;
          w_cnt_nxt    = w_reload;
        end
      end
      default: ;
    endcase
  end

  // Register counter and outputs; reset restarts at speed 0 with a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= CNT_W'(div_of(BASE_DIV, 0) - 1);
      r_tick   <= 1'b0;
      r_wave   <= 1'b0;
      r_active <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_tick   <= w_tick_nxt;
      r_wave   <= w_wave_nxt;
      r_active <= w_active_nxt;
    end
  end

  assign tick       = r_tick;
  assign wave       = r_wave;
  assign active_sel = r_active;
  assign running    = w_run;

endmodule

// File: tb/tb_speed_tick_sel.sv
// Directed bench for speed_tick_sel with N_SPEEDS=4, BASE_DIV=16 (DIV 16/8/4/2).
// Cycle numbers count rising edges since reset was released; outputs are
// sampled on the falling edge that follows each rising edge.
module tb_speed_tick_sel;

  logic       clk;
  logic       rst;
  logic [1:0] sw;
  logic       en;
  logic       tick;
  logic       wave;
  logic [1:0] active_sel;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  speed_tick_sel #(.N_SPEEDS(4), .BASE_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .en         (en),
    .tick       (tick),
    .wave       (wave),
    .active_sel (active_sel),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Advance n cycles, checking tick count, wave toggles and no back-to-back ticks.
  task automatic win(input int n, input int exp_ticks, input int exp_wchg, input string tag);
    int   nt    = 0;
    int   nw    = 0;
    int   nc    = 0;
    logic ptick = tick;
    logic pwave = wave;
    for (int i = 0; i < n; i++) begin
      step();
      if (tick === 1'b1) nt++;
      if (tick === 1'b1 && ptick === 1'b1) nc++;
      if (wave !== pwave) nw++;
      ptick = tick;
      pwave = wave;
    end
    chk(32'(nt), 32'(exp_ticks), {tag, "_ticks"});
    chk(32'(nw), 32'(exp_wchg), {tag, "_wave_toggles"});
    chk(32'(nc), 32'd0, {tag, "_consecutive"});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sw = 2'd0;
    repeat (3) step();
    chk(32'(tick), 0, "rst_tick");
    chk(32'(wave), 0, "rst_wave");
    chk(32'(active_sel), 0, "rst_active");
    chk(32'(running), 0, "rst_running");

    // Scenario 1/2: start at speed 0, switch to speed 2 at cycle 24.
    rst = 1'b0; cyc = 0;
    step(); chk(32'(running), 0, "s1_running_c1");
    step(); chk(32'(running), 1, "s1_running_c2");
    win(15, 0, 0, "s1_pre");
    step(); chk(32'(tick), 1, "s1_tick18"); chk(32'(wave), 1, "s1_wave18");
    chk(32'(active_sel), 0, "s1_active18");
    win(6, 0, 0, "s2_a");
    sw = 2'd2;
    win(9, 0, 0, "s2_b");
    chk(32'(active_sel), 0, "s2_active33");
    step(); chk(32'(tick), 1, "s2_tick34"); chk(32'(wave), 0, "s2_wave34");
    chk(32'(active_sel), 2, "s2_active34");
    win(3, 0, 0, "s2_c");
    step(); chk(32'(tick), 1, "s2_tick38");
    win(3, 0, 0, "s2_d");
    step(); chk(32'(tick), 1, "s2_tick42"); chk(32'(wave), 0, "s2_wave42");

    // Scenario 3: speed 3, tick every other cycle.
    sw = 2'd3;
    win(3, 0, 0, "s3_a");
    step(); chk(32'(tick), 1, "s3_tick46"); chk(32'(active_sel), 3, "s3_active46");
    chk(32'(wave), 1, "s3_wave46");
    win(20, 10, 10, "s3_alt");
    chk(32'(tick), 1, "s3_tick66"); chk(32'(wave), 1, "s3_wave66");

    // Scenario 4: speed 1, pause 3 cycles after the tick at 78.
    sw = 2'd1;
    win(3, 1, 1, "s4_a");
    step(); chk(32'(tick), 1, "s4_tick70"); chk(32'(active_sel), 1, "s4_active70");
    chk(32'(wave), 1, "s4_wave70");
    win(7, 0, 0, "s4_b");
    step(); chk(32'(tick), 1, "s4_tick78"); chk(32'(wave), 0, "s4_wave78");
    win(3, 0, 0, "s4_c");
    en = 1'b0;
    win(2, 0, 0, "s4_d");
    chk(32'(running), 0, "s4_running83");
    win(18, 0, 0, "s4_pause");
    chk(32'(running), 0, "s4_running101");
    en = 1'b1;
    win(2, 0, 0, "s4_e");
    chk(32'(running), 1, "s4_running103");
    win(2, 0, 0, "s4_f");
    step(); chk(32'(tick), 1, "s4_tick106"); chk(32'(wave), 1, "s4_wave106");

    // Scenario 5: paused re-select 1->2, then resume.
    en = 1'b0;
    win(4, 0, 0, "s5_a");
    sw = 2'd2;
    win(2, 0, 0, "s5_b");
    step(); chk(32'(active_sel), 2, "s5_active113");
    win(2, 0, 0, "s5_c");
    en = 1'b1;
    win(2, 0, 0, "s5_d");
    chk(32'(running), 1, "s5_running117");
    win(3, 0, 0, "s5_e");
    step(); chk(32'(tick), 1, "s5_tick121"); chk(32'(active_sel), 2, "s5_active121");
    chk(32'(wave), 0, "s5_wave121");

    // Scenario 6: reset mid-period at speed 2, then restart as scenario 1.
    win(2, 0, 0, "s6_a");
    rst = 1'b1; sw = 2'd0;
    step();
    chk(32'(tick), 0, "s6_rst_tick");
    chk(32'(wave), 0, "s6_rst_wave");
    chk(32'(active_sel), 0, "s6_rst_active");
    chk(32'(running), 0, "s6_rst_running");
    rst = 1'b0; cyc = 0;
    step(); chk(32'(running), 0, "s6_running_c1");
    step(); chk(32'(running), 1, "s6_running_c2");
    win(15, 0, 0, "s6_pre");
    step(); chk(32'(tick), 1, "s6_tick18"); chk(32'(wave), 1, "s6_wave18");
    chk(32'(active_sel), 0, "s6_active18");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
